// File: rtl/cbd_sampler_if.sv
// Stream bundle around the CBD sampler: PRF words in, coefficient beats out.
// A transfer happens on a rising clk edge where valid && ready; the source holds its data and valid
// stable until that edge, and ready may depend combinationally on the other stream.
interface cbd_sampler_if #(
  parameter int IN_W   = 32,
  parameter int LANES  = 1,
  parameter int COEF_W = 16
) ();
  logic [IN_W-1:0]         in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*COEF_W-1:0] out_coef;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_coef, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_coef, out_valid, out_last
  );
endinterface

// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: buffers PRF bits and emits LANES CBD_eta coefficients per beat.
// The bit buffer lets a word be appended while a beat is consumed in the same cycle.
module cbd_sampler #(
  parameter int ETA    = 2,
  parameter int IN_W   = 32,
  parameter int LANES  = 1,
  parameter int N      = 256,
  parameter int COEF_W = 16,
  parameter int MODQ   = 0,
  parameter int Q      = 3329
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  cbd_sampler_if.slave s,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  state_o
);
  localparam int BEAT_BITS = 2 * ETA * LANES;
  localparam int BUF_W     = IN_W + BEAT_BITS;
  localparam int WORDS     = N * 2 * ETA / IN_W;
  localparam int BEATS     = N / LANES;
  localparam int FILL_W    = $clog2(BUF_W + 1);
  localparam int WCNT_W    = $clog2(WORDS + 1);
  localparam int BCNT_W    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t                  state_q;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d, fill_after;
  logic [WCNT_W-1:0]       wcnt_q;
  logic [BCNT_W-1:0]       bcnt_q;
  logic [LANES*COEF_W-1:0] coef_q, coef_d;
  logic                    out_valid_q, out_last_q, busy_q, done_q;
  logic                    fire_beat, in_ready, accept;

  // A beat leaves the buffer only when the output register is free or being drained this cycle.
  assign fire_beat  = (state_q != IDLE) && (fill_q >= FILL_W'(BEAT_BITS)) &&
                      (!out_valid_q || s.out_ready);
  assign fill_after = fire_beat ? fill_q - FILL_W'(BEAT_BITS) : fill_q;
  // fill_after + IN_W <= BUF_W reduces to fill_after <= BEAT_BITS.
  assign in_ready   = (state_q == RUN) && (fill_after <= FILL_W'(BEAT_BITS));
  assign accept     = in_ready && s.in_valid;

  always_comb begin
    buf_d  = fire_beat ? (buf_q >> BEAT_BITS) : buf_q;
    fill_d = fill_after;
    if (accept) begin
      buf_d  = buf_d | (BUF_W'(s.in_data) << fill_after);
      fill_d = fill_after + FILL_W'(IN_W);
    end
  end

  always_comb begin
    coef_d = '0;
    for (int j = 0; j < LANES; j++) begin
      int c;
      c = 0;
      for (int k = 0; k < ETA; k++) begin
        c = c + int'(buf_q[2*ETA*j + k]) - int'(buf_q[2*ETA*j + ETA + k]);
      end
      if (MODQ != 0 && c < 0) c = c + Q;
      coef_d[j*COEF_W +: COEF_W] = COEF_W'(c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            buf_q   <= '0;
            fill_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
          end
        end
        RUN: begin
          buf_q  <= buf_d;
          fill_q <= fill_d;
          if (accept) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == WCNT_W'(WORDS - 1)) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          buf_q  <= buf_d;
          fill_q <= fill_d;
          if (out_valid_q && s.out_ready && out_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (fire_beat) begin
        coef_q      <= coef_d;
        out_valid_q <= 1'b1;
        out_last_q  <= (bcnt_q == BCNT_W'(BEATS - 1));
        bcnt_q      <= bcnt_q + 1'b1;
      end else if (s.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_coef  = coef_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_cbd_sampler.sv
// Bench for cbd_sampler: four configurations behind one shared driver/monitor, a software CBD model
// feeding an expected-beat queue, a vector table, and reset/restart sequences.
module tb_cbd_sampler;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_c;
  logic [31:0] in_data_c;
  logic        in_valid_c;
  logic        out_ready_c;
  int          sel;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  bit          mq[$];
  bit          abort;
  int          eta_cur, lanes_cur, modq_cur, words_cur, beats_cur;

  always #5 clk = ~clk;

  cbd_sampler_if #(.IN_W(32), .LANES(1), .COEF_W(16)) if_a ();
  cbd_sampler_if #(.IN_W(32), .LANES(2), .COEF_W(16)) if_b ();
  cbd_sampler_if #(.IN_W(32), .LANES(2), .COEF_W(16)) if_c ();
  cbd_sampler_if #(.IN_W(32), .LANES(1), .COEF_W(16)) if_d ();

  logic       busy_a, busy_b, busy_c, busy_d, done_a, done_b, done_c, done_d;
  logic [1:0] st_a, st_b, st_c, st_d;

  assign if_a.in_data = in_data_c;  assign if_a.in_valid = in_valid_c && (sel == 0);
  assign if_b.in_data = in_data_c;  assign if_b.in_valid = in_valid_c && (sel == 1);
  assign if_c.in_data = in_data_c;  assign if_c.in_valid = in_valid_c && (sel == 2);
  assign if_d.in_data = in_data_c;  assign if_d.in_valid = in_valid_c && (sel == 3);
  assign if_a.out_ready = out_ready_c && (sel == 0);
  assign if_b.out_ready = out_ready_c && (sel == 1);
  assign if_c.out_ready = out_ready_c && (sel == 2);
  assign if_d.out_ready = out_ready_c && (sel == 3);

  cbd_sampler #(.ETA(2), .LANES(1), .MODQ(0)) dut_a (.clk(clk), .reset(reset),
    .start_i(start_c && (sel == 0)), .s(if_a), .busy_o(busy_a), .done_o(done_a), .state_o(st_a));
  cbd_sampler #(.ETA(2), .LANES(2), .MODQ(0)) dut_b (.clk(clk), .reset(reset),
    .start_i(start_c && (sel == 1)), .s(if_b), .busy_o(busy_b), .done_o(done_b), .state_o(st_b));
  cbd_sampler #(.ETA(2), .LANES(2), .MODQ(1)) dut_c (.clk(clk), .reset(reset),
    .start_i(start_c && (sel == 2)), .s(if_c), .busy_o(busy_c), .done_o(done_c), .state_o(st_c));
  cbd_sampler #(.ETA(3), .LANES(1), .MODQ(0)) dut_d (.clk(clk), .reset(reset),
    .start_i(start_c && (sel == 3)), .s(if_d), .busy_o(busy_d), .done_o(done_d), .state_o(st_d));

  logic        in_ready_m, out_valid_m, out_last_m, busy_m, done_m;
  logic [31:0] out_coef_m;
  logic [1:0]  state_m;

  always_comb begin
    in_ready_m = 1'b0; out_valid_m = 1'b0; out_last_m = 1'b0;
    busy_m = 1'b0; done_m = 1'b0; out_coef_m = '0; state_m = '0;
    case (sel)
      0: begin in_ready_m = if_a.in_ready; out_valid_m = if_a.out_valid; out_last_m = if_a.out_last;
               busy_m = busy_a; done_m = done_a; out_coef_m = {16'h0, if_a.out_coef}; state_m = st_a; end
      1: begin in_ready_m = if_b.in_ready; out_valid_m = if_b.out_valid; out_last_m = if_b.out_last;
               busy_m = busy_b; done_m = done_b; out_coef_m = if_b.out_coef; state_m = st_b; end
      2: begin in_ready_m = if_c.in_ready; out_valid_m = if_c.out_valid; out_last_m = if_c.out_last;
               busy_m = busy_c; done_m = done_c; out_coef_m = if_c.out_coef; state_m = st_c; end
      default: begin in_ready_m = if_d.in_ready; out_valid_m = if_d.out_valid; out_last_m = if_d.out_last;
               busy_m = busy_d; done_m = done_d; out_coef_m = {16'h0, if_d.out_coef}; state_m = st_d; end
    endcase
  end

  typedef struct {
    int          sel;
    logic [31:0] first_w;
    logic [31:0] rest_w;
    bit          rnd;
    bit          use_exp;
    logic [31:0] exp_first;
    logic [31:0] exp_rest;
    int          stall_at;
    bit          rnd_ready;
    bit          offer_extra;
  } row_t;

  row_t rows[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_sel(input int s);
    sel = s;
    eta_cur   = (s == 3) ? 3 : 2;
    lanes_cur = (s == 1 || s == 2) ? 2 : 1;
    modq_cur  = (s == 2) ? 1 : 0;
    words_cur = 256 * 2 * eta_cur / 32;
    beats_cur = 256 / lanes_cur;
  endtask

  // Reference CBD: append the word LSB-first, then cut whole beats from the front of the stream.
  task automatic model_push(input logic [31:0] w);
    logic [31:0] e;
    int a, b, c;
    for (int i = 0; i < 32; i++) mq.push_back(w[i]);
    while (mq.size() >= 2 * eta_cur * lanes_cur) begin
      e = '0;
      for (int j = 0; j < lanes_cur; j++) begin
        a = 0; b = 0;
        for (int k = 0; k < eta_cur; k++) a += int'(mq.pop_front());
        for (int k = 0; k < eta_cur; k++) b += int'(mq.pop_front());
        c = a - b;
        if (modq_cur != 0 && c < 0) c = c + 3329;
        e[j*16 +: 16] = c[15:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run_poly(input row_t r, input int abort_at, input bit extra_start);
    logic [31:0] dword, held, e;
    bit          hs, acc, have_held, stall_used;
    int          wc, bad, beat, cyc, stall_left;
    set_sel(r.sel);
    mq.delete();
    exp_q.delete();
    abort = 1'b0;
    out_ready_c = 1'b1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    check("busy_after_start", 64'(busy_m), 64'd1);
    fork
      begin : driver
        for (int w = 0; w < words_cur && !abort; w++) begin
          dword = r.rnd ? $urandom() : ((w == 0) ? r.first_w : r.rest_w);
          in_data_c = dword;
          in_valid_c = 1'b1;
          acc = 1'b0;
          wc = 0;
          while (!acc && !abort && wc < 500) begin
            @(negedge clk);
            hs = in_ready_m;
            @(posedge clk); #1;
            wc++;
            if (hs) acc = 1'b1;
          end
          in_valid_c = 1'b0;
          if (acc) model_push(dword);
          else if (!abort) begin
            check("in_accept_timeout", 64'd0, 64'd1);
            abort = 1'b1;
          end
          if (acc && extra_start && w == 5) begin
            start_c = 1'b1;
            @(posedge clk); #1;
            start_c = 1'b0;
          end
        end
        in_valid_c = 1'b0;
        if (r.offer_extra && !abort) begin
          in_data_c = 32'hDEAD_BEEF;
          in_valid_c = 1'b1;
          bad = 0;
          repeat (8) begin
            @(negedge clk);
            if (in_ready_m) bad++;
          end
          @(posedge clk); #1;
          in_valid_c = 1'b0;
          check("extra_word_refused", 64'(bad), 64'd0);
        end
      end
      begin : monitor
        beat = 0; cyc = 0; stall_left = 0; stall_used = 1'b0; have_held = 1'b0; held = '0;
        while (beat < beats_cur && !abort && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          if (out_valid_m && out_ready_c) begin
            if (exp_q.size() == 0) check("model_has_beat", 64'd0, 64'd1);
            else begin
              e = exp_q.pop_front();
              check("coef_vs_model", 64'(out_coef_m), 64'(e));
            end
            if (r.use_exp)
              check("coef_vs_table", 64'(out_coef_m), 64'((beat == 0) ? r.exp_first : r.exp_rest));
            check("out_last", 64'(out_last_m), 64'(beat == beats_cur - 1));
            have_held = 1'b0;
            beat++;
            if (abort_at > 0 && beat == abort_at) abort = 1'b1;
          end else if (out_valid_m) begin
            if (have_held) check("hold_stable", 64'(out_coef_m), 64'(held));
            else begin held = out_coef_m; have_held = 1'b1; end
          end
          if (stall_left == 1) check("in_ready_low_in_stall", 64'(in_ready_m), 64'd0);
          @(posedge clk); #1;
          if (stall_left > 0) stall_left--;
          else if (r.stall_at >= 0 && !stall_used && beat >= r.stall_at) begin
            stall_left = 10;
            stall_used = 1'b1;
          end
          out_ready_c = (stall_left > 0) ? 1'b0 : (r.rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
        out_ready_c = 1'b1;
        if (beat < beats_cur && !abort) begin
          check("beat_count", 64'(beat), 64'(beats_cur));
          abort = 1'b1;
        end
        if (beat == beats_cur) begin
          @(negedge clk);
          check("done_busy_after_last", {62'd0, done_m, busy_m}, 64'b10);
          @(negedge clk);
          check("done_single_pulse", 64'(done_m), 64'd0);
          check("model_drained", 64'(exp_q.size()), 64'd0);
        end
      end
    join
  endtask

  initial begin
    reset = 1'b1; start_c = 1'b0; in_data_c = '0; in_valid_c = 1'b0; out_ready_c = 1'b1;
    set_sel(0);
    rows[0] = '{0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, -1, 1'b0, 1'b0};
    rows[1] = '{1, 32'hC3C3_C3C3, 32'hC3C3_C3C3, 1'b0, 1'b1, 32'hFFFE_0002, 32'hFFFE_0002, -1, 1'b0, 1'b0};
    rows[2] = '{2, 32'hC3C3_C3C3, 32'hC3C3_C3C3, 1'b0, 1'b1, 32'h0CFF_0002, 32'h0CFF_0002, -1, 1'b0, 1'b0};
    rows[3] = '{3, 32'h0000_0007, 32'h0,         1'b0, 1'b1, 32'h0000_0003, 32'h0000_0000, -1, 1'b0, 1'b1};
    rows[4] = '{1, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         50, 1'b0, 1'b0};
    rows[5] = '{2, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         -1, 1'b1, 1'b0};
    rows[6] = '{3, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         -1, 1'b1, 1'b0};
    rows[7] = '{0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         -1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      set_sel(s);
      #1;
      check("reset_outputs", {21'd0, in_ready_m, out_valid_m, out_last_m, busy_m, done_m, state_m, out_coef_m},
            64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_poly(rows[i], 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
    end

    // Abandon a polynomial after 101 beats with an asynchronous reset, then restart cleanly.
    run_poly(rows[7], 101, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_run", {21'd0, in_ready_m, out_valid_m, out_last_m, busy_m, done_m, state_m, out_coef_m},
          64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_poly(rows[7], 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cbd_sampler.md
# cbd_sampler

Parametrised centered-binomial-distribution sampler for the Kyber secret/error path, replacing the fixed η=2, 32-word, RAM-buffered sampler. It sits between the PRF/SHAKE output stream and the polynomial RAM/NTT input. It consumes PRF words through a valid/ready stream and emits `LANES` coefficients per beat through a second valid/ready stream. η (2 or 3), input word width, lane count, polynomial length and output encoding (signed or mod q) are compile-time selectable.

## Interface
- `ETA`, 2, CBD parameter η; legal values 2 and 3.
- `IN_W`, 32, PRF input word width in bits.
- `LANES`, 1, coefficients per output beat; legal values 1, 2, 4.
- `N`, 256, coefficients per polynomial.
- `COEF_W`, 16, width of each output coefficient.
- `MODQ`, 0, output encoding: 0 gives signed two's complement; 1 gives the value reduced into [0, Q).
- `Q`, 3329, modulus used when `MODQ`=1.
- Legality: `N*2*ETA` is a multiple of `IN_W`; `N` is a multiple of `LANES`; `2*ETA*LANES` ≤ `IN_W`.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins one polynomial.
- `in_data` in `IN_W`: PRF word. The LSB is the earliest bit of the stream.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: sampler accepts `in_data` this cycle.
- `out_coef` out `LANES*COEF_W`: lane j occupies bits [j*COEF_W +: COEF_W] and carries coefficient beat*LANES+j.
- `out_valid` out 1: `out_coef` is valid.
- `out_ready` in 1: consumer takes the beat.
- `out_last` out 1: high with the final beat of the polynomial.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse after the last beat is taken.

## Operation
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE → RUN on `start`. The word counter, beat counter and bit buffer are cleared.
  - RUN → FLUSH when `WORDS = N*2*ETA/IN_W` words have been accepted.
  - FLUSH → IDLE when the beat with `out_last` is taken; `done` pulses for that one transition cycle.
  - `start` in RUN or FLUSH is ignored.
- **Bit buffer:**
  - Width `BUF_W = IN_W + 2*ETA*LANES`. Holds a fill count `fill` (0..BUF_W).
  - New words are appended above the existing valid bits.
  - `in_ready` = (state==RUN) && (fill − consumed_this_cycle + IN_W ≤ BUF_W).
  - Accept and consume may occur in the same cycle; the buffer shifts right by the consumed bits and the new word is appended in one update.
- **Sampling:**
  - A beat is formed when `fill ≥ 2*ETA*LANES` and the output register is empty or being drained.
  - For lane j with base = 2*ETA*j: a = popcount(bits[base +: ETA]), b = popcount(bits[base+ETA +: ETA]), c = a − b, range [−ETA, ETA].
  - With `MODQ`=0, c is sign-extended to `COEF_W`. With `MODQ`=1, c<0 outputs c+Q, else c.
- **Output register:**
  - `out_coef`, `out_valid`, `out_last` hold stable while `out_valid && !out_ready`.
  - `out_last` asserts on beat N/LANES−1.
- **Boundary conditions:**
  - After `WORDS` words have been accepted, `in_ready` stays 0 until the next `start`; extra PRF words are not consumed.
  - In FLUSH, the remaining buffered bits drain. `fill` is 0 when `out_last` is taken.
  - `reset` at any time forces IDLE, fill=0, and all outputs to 0; a partial polynomial is discarded.
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_coef`=0, `out_last`=0, `busy`=0, `done`=0.

## Timing
- Word accepted in cycle k → buffer updated at end of k → first beat registered at end of k+1 → `out_valid` high in cycle k+2.
- Sustained throughput is 1 beat/cycle when `in_valid` and `out_ready` are held high, since the legality rule gives 2·η·LANES ≤ IN_W.
- Backpressure: with `out_ready` low, the buffer fills. `in_ready` drops within one cycle of `fill+IN_W` exceeding `BUF_W`, and no bits are lost.
- `done` rises the cycle after the `out_last` handshake. `busy` falls in that same cycle. `start` is accepted in the cycle after `done`.

## Test plan
- **ETA=2, LANES=1, MODQ=0, all-zero input:** 32 words of 0x00000000 → 256 beats of 0x0000. `out_last` is high on beat 255 only, then `done` pulses once.
- **ETA=2, LANES=2, MODQ=0, alternating-sign pattern:** 32 words of 0xC3C3C3C3 → lane0=+2 (0x0002) and lane1=−2 (0xFFFE) on every beat, 128 beats total.
- **Same pattern with MODQ=1:** lane1 = 3327 (0x0CFF). Randomised words are compared against a software CBD_η model.
- **ETA=3, LANES=1, single set bit-field:** first word 0x00000007 and all remaining 47 words 0 → coefficient 0 = +3, all others 0. `in_ready` stays 0 after word 48; a 49th offered word is not taken.
- **Backpressure:** hold `out_ready` low for 10 cycles mid-polynomial → `in_ready` deasserts and `out_coef` is held stable. The full coefficient sequence still matches the model with none dropped or duplicated.
- **Reset mid-run:** assert `reset` after beat 100 → all outputs go to 0 at once. A fresh `start` then gives correct results from coefficient 0, and a `start` pulse issued during RUN is ignored.
